glyph_row_reader: RTL and testbench
===================================

// Module: glyph_row_reader
// PURPOSE
//   Read-side master for the 1-bit glyph ROMs (128 x 1, 7-bit address, q registered on posedge).
//   On a start pulse it walks one glyph's 16 rows x 8 columns, assembles each row into a byte
//   and hands the bytes downstream over a valid/ready handshake, one row at a time.
//   Sits between a glyph ROM and the display/compositor path.
// PARAMETERS
//   GLYPH_W  8   columns per row; ROM address = row*GLYPH_W + col
//   GLYPH_H  16  rows per glyph; GLYPH_W*GLYPH_H must equal 2**ADDR_W
//   ADDR_W   7   ROM address width
//   ROM_LAT  1   ROM read latency in clock edges (address sampled -> q valid)
// PORTS
//   clock       in   1        single clock; all logic on posedge
//   reset       in   1        asynchronous, active-high reset
//   start       in   1        one-cycle request to read a full glyph; ignored while busy=1
//   busy        out  1        high from the start-accept edge until done
//   rom_address out  ADDR_W   registered address to ROM
//   rom_q       in   1        ROM data bit, valid ROM_LAT edges after rom_address is sampled
//   row_data    out  GLYPH_W  assembled row; col 0 in MSB (row_data[GLYPH_W-1])
//   row_index   out  4        row number of row_data, 0..GLYPH_H-1
//   row_valid   out  1        row_data/row_index valid; held until accepted
//   row_ready   in   1        downstream accepts when row_valid & row_ready at posedge
//   done        out  1        one-cycle pulse after last row (row GLYPH_H-1) accepted
// BEHAVIOUR
//   Reset values: busy=0, rom_address=0, row_data=0, row_index=0, row_valid=0, done=0, state IDLE.
//   States: IDLE -> FETCH -> DRAIN -> PRESENT -> (FETCH for next row | DONE) ; DONE -> IDLE.
//   IDLE: on start=1 at edge E0: busy<=1, row<=0, col<=0, rom_address<=0, go FETCH.
//   FETCH: one address per cycle; col k of current row driven from edge Ek; after col GLYPH_W-1
//     issued go DRAIN. rom_address holds last value outside FETCH.
//   Capture: issue-valid delayed by ROM_LAT+1 edges tags each rom_q sample; each tagged sample
//     shifts into the row shift register from LSB side, so first column ends in MSB.
//   DRAIN: wait until all GLYPH_W bits captured (ROM_LAT+1 edges after last issue); on the edge
//     capturing the last bit: row_data<=assembled byte, row_index<=row, row_valid<=1, go PRESENT.
//   Latency (ROM_LAT=1): start edge E0 -> row_valid first high after E9 (9 clocks).
//   PRESENT: row_data/row_index stable while row_valid=1 and row_ready=0 (back-pressure, no limit).
//     On row_valid&row_ready: row_valid<=0; if row<GLYPH_H-1: row<=row+1, col<=0,
//     rom_address<=(row+1)*GLYPH_W, go FETCH (same edge); else go DONE.
//   DONE: done<=1 for exactly one cycle, busy<=0, return IDLE; row_data keeps last row.
//   Row period with row_ready tied high: 10 clocks (9 fetch/drain + 1 handshake); glyph = 160 clocks.
//   start while busy (any state but IDLE) has no effect; start in DONE cycle also ignored.
//   rom_address arithmetic: row*GLYPH_W + col, ADDR_W bits; never exceeds 2**ADDR_W-1, no wrap.
//   Reset mid-operation (any state): all outputs return to reset values immediately (async);
//     in-flight ROM data discarded; next start after reset release begins at row 0.
//   No partial rows ever presented; row_valid never drops without handshake except by reset.
// TESTING (bench ROM model: registered 128x1, ROM_LAT=1, loaded with digit '8' glyph)
//   1 Reset: assert reset mid-FETCH of row 4 -> all outputs 0 same cycle; restart reads row 0=8'h00.
//   2 start, row_ready=1 -> row_valid first at 9 clocks; rows 0..2=8'h00, row3=8'h3C,
//     row4=8'h76, row8=8'h77, row11=8'h36, rows 12..15=8'h00; done pulse once; 160 clocks total.
//   3 Address trace: rom_address sequence 0..7, hold, 8..15, ..., 120..127; no value >127.
//   4 Back-pressure: row_ready=0 for 20 clocks at row 3 -> row_data=8'h3C, row_index=3 stable,
//     no new rom_address issued; release -> row 4 fetch starts on accept edge.
//   5 start pulsed during rows 5 and 15 and in DONE cycle -> ignored; exactly 16 rows, one done.
//   6 Back-to-back: start on cycle after done -> second glyph identical byte sequence.

Source files
------------

// File: rtl/glyph_row_reader.sv
// Read-side master for a 1-bit glyph ROM: walks GLYPH_H rows of GLYPH_W columns,
// packs each row MSB-first and presents it downstream one row at a time.
module glyph_row_reader #(
  parameter int GLYPH_W = 8,
  parameter int GLYPH_H = 16,
  parameter int ADDR_W  = 7,
  parameter int ROM_LAT = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic [ADDR_W-1:0]  rom_address,
  input  logic               rom_q,
  output logic [GLYPH_W-1:0] row_data,
  output logic [3:0]         row_index,
  output logic               row_valid,
  input  logic               row_ready,
  output logic               done,
  output logic [2:0]         state_o
);

  localparam int COL_W = $clog2(GLYPH_W);
  localparam int ROW_W = $clog2(GLYPH_H);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DRAIN   = 3'd2,
    S_PRESENT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  // Handshake: a row transfers on any posedge where row_valid and row_ready are
  // both high; row_data/row_index are held unchanged while row_valid waits.

  state_t               state_q;
  logic [ROW_W-1:0]     row_q;
  logic [COL_W-1:0]     col_q;
  logic [COL_W-1:0]     cap_cnt_q;
  logic [GLYPH_W-2:0]   shift_q;
  logic [ROM_LAT:0]     issue_pipe_q;
  logic                 busy_q;
  logic [ADDR_W-1:0]    rom_addr_q;
  logic [GLYPH_W-1:0]   row_data_q;
  logic [3:0]           row_index_q;
  logic                 row_valid_q;
  logic                 done_q;

  logic                 issue_d;
  logic [ADDR_W-1:0]    rom_addr_d;
  logic [ADDR_W-1:0]    next_base_d;
  logic                 capture;
  logic                 cap_last;
  logic                 col_last;
  logic                 row_last;
  logic                 accept;

  assign capture     = issue_pipe_q[ROM_LAT];
  assign cap_last    = (cap_cnt_q == COL_W'(GLYPH_W - 1));
  assign col_last    = (col_q == COL_W'(GLYPH_W - 1));
  assign row_last    = (row_q == ROW_W'(GLYPH_H - 1));
  assign accept      = row_valid_q & row_ready;
  assign next_base_d = ADDR_W'((int'(row_q) + 1) * GLYPH_W);

  // Address issue: each cycle that drives a fresh ROM address also tags the
  // capture pipeline so the matching rom_q bit is picked up ROM_LAT+1 edges later.
  always_comb begin
    issue_d    = 1'b0;
    rom_addr_d = rom_addr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          issue_d    = 1'b1;
          rom_addr_d = '0;
        end
      end
      S_FETCH: begin
        if (!col_last) begin
          issue_d    = 1'b1;
          rom_addr_d = rom_addr_q + ADDR_W'(1);
        end
      end
      S_PRESENT: begin
        if (accept && !row_last) begin
          issue_d    = 1'b1;
          rom_addr_d = next_base_d;
        end
      end
      default: begin
        issue_d    = 1'b0;
        rom_addr_d = rom_addr_q;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      row_q        <= '0;
      col_q        <= '0;
      cap_cnt_q    <= '0;
      shift_q      <= '0;
      issue_pipe_q <= '0;
      busy_q       <= 1'b0;
      rom_addr_q   <= '0;
      row_data_q   <= '0;
      row_index_q  <= '0;
      row_valid_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      issue_pipe_q <= {issue_pipe_q[ROM_LAT-1:0], issue_d};
      rom_addr_q   <= rom_addr_d;
      done_q       <= 1'b0;

      // First captured column shifts toward the MSB as later columns arrive.
      if (capture) begin
        shift_q   <= {shift_q[GLYPH_W-3:0], rom_q};
        cap_cnt_q <= cap_last ? '0 : cap_cnt_q + COL_W'(1);
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q  <= 1'b1;
            row_q   <= '0;
            col_q   <= '0;
            state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (col_last) begin
            state_q <= S_DRAIN;
          end else begin
            col_q <= col_q + COL_W'(1);
          end
        end
        S_DRAIN: begin
          if (capture && cap_last) begin
            row_data_q  <= {shift_q, rom_q};
            row_index_q <= 4'(row_q);
            row_valid_q <= 1'b1;
            state_q     <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (accept) begin
            row_valid_q <= 1'b0;
            if (!row_last) begin
              row_q   <= row_q + ROW_W'(1);
              col_q   <= '0;
              state_q <= S_FETCH;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign rom_address = rom_addr_q;
  assign row_data    = row_data_q;
  assign row_index   = row_index_q;
  assign row_valid   = row_valid_q;
  assign done        = done_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_glyph_row_reader.sv
// Bench for glyph_row_reader: registered 128x1 ROM holding a digit '8' glyph,
// row-level scoreboard, timing model in rows/clocks, and directed scenarios.
module tb_glyph_row_reader;

  logic       clock;
  logic       reset;
  logic       start;
  logic       busy;
  logic [6:0] rom_address;
  logic       rom_q;
  logic [7:0] row_data;
  logic [3:0] row_index;
  logic       row_valid;
  logic       row_ready;
  logic       done;
  logic [2:0] state_o;

  glyph_row_reader dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .busy        (busy),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .row_data    (row_data),
    .row_index   (row_index),
    .row_valid   (row_valid),
    .row_ready   (row_ready),
    .done        (done),
    .state_o     (state_o)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // glyph ROM model
  logic [7:0] glyph [16];
  logic       rom_mem [128];
  always @(posedge clock) rom_q <= rom_mem[rom_address];

  // scoreboard state
  logic [11:0] exp_q [$];
  logic [6:0]  trace_q [$];
  logic [7:0]  got_row [16];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          rows_acc = 0;
  int          done_cnt = 0;
  bit          trace_en = 0;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // compare process: row transfers, hold under back-pressure, done width, address trace
  bit         prev_hold = 0;
  bit         prev_done = 0;
  logic [7:0] hold_data;
  logic [3:0] hold_idx;
  logic [11:0] exp_row;

  always @(negedge clock) begin
    if (reset) begin
      prev_hold = 0;
      prev_done = 0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", int'(row_valid), 1);
        check("hold_data", int'(row_data), int'(hold_data));
        check("hold_index", int'(row_index), int'(hold_idx));
      end
      if (row_valid && row_ready) begin
        prev_hold = 0;
        rows_acc++;
        got_row[row_index] = row_data;
        if (exp_q.size() == 0) begin
          check("row_extra", 1, 0);
        end else begin
          exp_row = exp_q.pop_front();
          check("row", int'({row_index, row_data}), int'(exp_row));
        end
      end else if (row_valid) begin
        prev_hold = 1;
        hold_data = row_data;
        hold_idx  = row_index;
      end else begin
        prev_hold = 0;
      end
      if (done) begin
        done_cnt++;
        if (prev_done) check("done_pulse", int'(prev_done), 0);
      end
      prev_done = done;
      if (trace_en && (trace_q.size() == 0 || trace_q[$] != rom_address))
        trace_q.push_back(rom_address);
    end
  end

  // driver: one full glyph read, optional back-pressure and spurious starts
  task automatic run_glyph(input bit spurious, input int stall_row, input int stall_len);
    int s;
    int cur;
    int stall_done;
    bit prev_v;
    bit chk_next;
    bit finished;
    logic [6:0] stall_addr;
    stall_addr = '0;
    for (int r = 0; r < 16; r++) exp_q.push_back({4'(r), glyph[r]});
    for (int r = 0; r < 16; r++) got_row[r] = 8'hxx;
    rows_acc = 0;
    trace_q.delete();
    @(posedge clock); #1;
    check("idle_busy", int'(busy), 0);
    check("idle_done", int'(done), 0);
    start = 1'b1;
    row_ready = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    s = cyc;
    trace_en = 1;
    check("busy_on", int'(busy), 1);
    finished = 0; prev_v = 0; stall_done = 0; chk_next = 0;
    for (int n = 0; n < 600 && !finished; n++) begin
      cur = cyc - s;
      if (chk_next) begin
        check("bp_next_addr", int'(rom_address), (stall_row + 1) * 8);
        check("bp_valid_drop", int'(row_valid), 0);
        chk_next = 0;
      end
      if (row_valid && !prev_v && stall_len == 0)
        check("row_time", cur, 9 + 10 * int'(row_index));
      prev_v = row_valid;
      row_ready = 1'b1;
      if (stall_len > 0 && row_valid && int'(row_index) == stall_row) begin
        if (stall_done < stall_len) begin
          if (stall_done == 0) stall_addr = rom_address;
          else begin
            check("bp_addr", int'(rom_address), int'(stall_addr));
            check("bp_data", int'(row_data), 8'h3C);
            check("bp_index", int'(row_index), 3);
          end
          row_ready = 1'b0;
          stall_done++;
        end else begin
          chk_next = 1;
        end
      end
      start = spurious && (cur == 55 || cur == 155 || cur == 160);
      if (done) begin
        finished = 1;
        trace_en = 0;
        if (stall_len == 0) check("done_time", cur, 160);
      end else begin
        @(posedge clock); #1;
      end
    end
    if (!finished) begin
      trace_en = 0;
      check("timeout", 0, 1);
    end
    if (spurious) begin
      @(posedge clock); #1;
      start = 1'b0;
      repeat (3) begin @(posedge clock); #1; end
      check("spur_busy", int'(busy), 0);
      check("spur_valid", int'(row_valid), 0);
    end
    check("rows_count", rows_acc, 16);
    check("exp_empty", exp_q.size(), 0);
    check("trace_len", trace_q.size(), 128);
    for (int i = 0; i < 128 && i < trace_q.size(); i++)
      check("trace_addr", int'(trace_q[i]), i);
  endtask

  initial begin
    glyph = '{8'h00, 8'h00, 8'h00, 8'h3C, 8'h76, 8'h66, 8'h76, 8'h3C,
              8'h77, 8'h63, 8'h63, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 8; c++)
        rom_mem[r * 8 + c] = glyph[r][7 - c];
    reset = 1'b1;
    start = 1'b0;
    row_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_addr", int'(rom_address), 0);
    check("rst_data", int'(row_data), 0);
    check("rst_index", int'(row_index), 0);
    check("rst_valid", int'(row_valid), 0);
    check("rst_done", int'(done), 0);
    reset = 1'b0;

    // full glyph, ready always high
    run_glyph(0, -1, 0);
    check("pin_row0", int'(got_row[0]), 8'h00);
    check("pin_row3", int'(got_row[3]), 8'h3C);
    check("pin_row4", int'(got_row[4]), 8'h76);
    check("pin_row8", int'(got_row[8]), 8'h77);
    check("pin_row11", int'(got_row[11]), 8'h36);
    check("pin_row15", int'(got_row[15]), 8'h00);

    // back-pressure at row 3 for 20 clocks
    run_glyph(0, 3, 20);

    // starts during rows 5, 15 and the done cycle
    run_glyph(1, -1, 0);

    // back-to-back glyphs
    run_glyph(0, -1, 0);
    run_glyph(0, -1, 0);
    check("b2b_row4", int'(got_row[4]), 8'h76);

    // reset mid-fetch of row 4, then restart from row 0
    for (int r = 0; r < 16; r++) exp_q.push_back({4'(r), glyph[r]});
    @(posedge clock); #1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    begin
      int s;
      s = cyc;
      for (int n = 0; n < 100 && (cyc - s) < 43; n++) begin
        @(posedge clock); #1;
      end
      check("pre_rst_index", int'(row_index), 3);
    end
    reset = 1'b1;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_addr", int'(rom_address), 0);
    check("arst_data", int'(row_data), 0);
    check("arst_index", int'(row_index), 0);
    check("arst_valid", int'(row_valid), 0);
    check("arst_done", int'(done), 0);
    exp_q.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    run_glyph(0, -1, 0);
    check("post_rst_row0", int'(got_row[0]), 8'h00);

    repeat (2) @(posedge clock);
    #1;
    check("done_total", done_cnt, 6);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
